// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The controller uses the slave
// modport; the pipeline (or a bench) uses master.
interface hazard_ctrl_if #(
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 16
);
  logic            ihit;
  logic            dhit;
  logic            mem_req;
  logic            ex_memread;
  logic [REGW-1:0] ex_rd;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_uses_rt;
  logic            br_taken;
  logic            halt_wb;
  logic            pc_en;
  logic            ifid_en;
  logic            idex_en;
  logic            exmem_en;
  logic            memwb_en;
  logic            ifid_flush;
  logic            idex_flush;
  logic            exmem_flush;
  logic            halted;
  logic [CNTW-1:0] stall_cycles;

  modport master (
    output ihit, dhit, mem_req, ex_memread, ex_rd, id_rs, id_rt, id_uses_rt, br_taken, halt_wb,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
    input  halted, stall_cycles
  );

  modport slave (
    input  ihit, dhit, mem_req, ex_memread, ex_rd, id_rs, id_rt, id_uses_rt, br_taken, halt_wb,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
    output halted, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, memory-wait freezes, branch
// flushes and halt drain, plus a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

  state_e          state_q, state_d;
  logic            halted_q;
  logic [CNTW-1:0] stall_q;

  logic lu, dwait, eval_run;
  // {pc, ifid, idex, exmem, memwb} enables and {ifid, idex, exmem} flushes
  logic [4:0] en_c;
  logic [2:0] fl_c;

  assign lu = hz.ex_memread && (hz.ex_rd != '0) &&
              ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
  assign dwait = hz.mem_req && !hz.dhit;

  // The MEMWAIT exit cycle (dhit=1) is evaluated exactly like RUN, where dwait is 0.
  assign eval_run = (state_q == StRun) || ((state_q == StMemWait) && hz.dhit);

  always_comb begin
    state_d = state_q;
    en_c    = 5'b00000;
    fl_c    = 3'b000;
    if (eval_run) begin
      state_d = StRun;
      if (hz.halt_wb) begin
        state_d = StHalt;
      end else if (dwait) begin
        state_d = StMemWait;
      end else if (hz.br_taken) begin
        en_c = 5'b11111;
        fl_c = 3'b111;
      end else if (lu) begin
        en_c = 5'b00111;
        fl_c = 3'b010;
      end else if (!hz.ihit) begin
        en_c = 5'b01111;
        fl_c = 3'b100;
      end else begin
        en_c = 5'b11111;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StRun;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == StHalt);
      if (!en_c[4] && (state_q != StHalt) && (state_d != StHalt) && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign hz.pc_en        = en_c[4] && !RST;
  assign hz.ifid_en      = en_c[3] && !RST;
  assign hz.idex_en      = en_c[2] && !RST;
  assign hz.exmem_en     = en_c[1] && !RST;
  assign hz.memwb_en     = en_c[0] && !RST;
  assign hz.ifid_flush   = fl_c[2] && !RST;
  assign hz.idex_flush   = fl_c[1] && !RST;
  assign hz.exmem_flush  = fl_c[0] && !RST;
  assign hz.halted       = halted_q;
  assign hz.stall_cycles = stall_q;

endmodule
